// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and port ids.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam logic PORT_CORE   = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin pick: a lone request wins; on a tie the port not
// granted last time wins.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt_onehot,
  output logic       any
);

  always_comb begin
    gnt_onehot = req;
    if (req == 2'b11) begin
      gnt_onehot = 2'b00;
      if (last_gnt == PORT_LOADER) gnt_onehot[PORT_CORE]   = 1'b1;
      else                         gnt_onehot[PORT_LOADER] = 1'b1;
    end
  end

  assign any = |req;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the core LSU and the loader.
// Optional address range check: define DMEM_ARB_ADDR_CHECK_EN (adds err port).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
`ifdef DMEM_ARB_ADDR_CHECK_EN
  output logic              err,
`endif
  output logic [ADDR_W-1:0] mem_A,
  output logic              mem_WE,
  output logic [DATA_W-1:0] mem_WriteData,
  input  logic [DATA_W-1:0] mem_ReadData
);

  arb_state_t        state, state_nxt;
  logic              accept;
  logic              last_gnt;
  logic [1:0]        gnt_onehot;
  logic              any;
  logic              win;
  logic              vld_p1, vld_p2;
  logic              owner_p1;
  logic              we_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;

  rr_arb2 u_rr (
    .req        ({req1, req0}),
    .last_gnt   (last_gnt),
    .gnt_onehot (gnt_onehot),
    .any        (any)
  );

  assign win = gnt_onehot[PORT_LOADER];

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          state_nxt = ISSUE;
          accept    = 1'b1;
        end
      end
      ISSUE: state_nxt = RESP;
      RESP: begin
        if (any) begin
          state_nxt = ISSUE;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: accepted request latched, memory driven during ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= PORT_LOADER;
      owner_p1 <= PORT_CORE;
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_gnt <= win;
        owner_p1 <= win;
        we_p1    <= gnt_onehot[PORT_CORE] ? we0    : we1;
        addr_p1  <= gnt_onehot[PORT_CORE] ? addr0  : addr1;
        wdata_p1 <= gnt_onehot[PORT_CORE] ? wdata0 : wdata1;
      end
    end
  end

  assign vld_p1        = (state == ISSUE);
  assign mem_A         = addr_p1;
  assign mem_WriteData = wdata_p1;
  assign gnt0          = vld_p1 && (owner_p1 == PORT_CORE);
  assign gnt1          = vld_p1 && (owner_p1 == PORT_LOADER);

  // Stage p2: registered memory read is valid, response routed to owner
  assign vld_p2  = (state == RESP);
  assign rvalid0 = vld_p2 && (owner_p1 == PORT_CORE);
  assign rvalid1 = vld_p2 && (owner_p1 == PORT_LOADER);

`ifdef DMEM_ARB_ADDR_CHECK_EN
  function automatic logic addr_oob(input logic [ADDR_W-1:0] a);
    return 64'(a) >= 64'(DEPTH);
  endfunction

  logic oob_p1;
  assign oob_p1 = addr_oob(addr_p1);
  assign mem_WE = vld_p1 && we_p1 && !oob_p1;
  assign err    = vld_p2 && oob_p1;
  assign rdata  = (vld_p2 && oob_p1) ? '0 : mem_ReadData;
`else
  assign mem_WE = vld_p1 && we_p1;
  assign rdata  = mem_ReadData;

  // DEPTH only feeds the range check; this keeps it referenced without it.
  if (DEPTH < 1) begin : g_depth_invalid
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter with a transaction-level reference model
// and a behavioural read-before-write data memory.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

`ifdef DMEM_ARB_ADDR_CHECK_EN
  localparam bit OOB_CHECK = 1'b1;
`else
  localparam bit OOB_CHECK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_a;
  logic [1:0]  we_a;
  logic [31:0] addr_a  [2];
  logic [31:0] wdata_a [2];
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata;
  logic [31:0] mem_A;
  logic        mem_WE;
  logic [31:0] mem_WriteData;
  logic [31:0] mem_ReadData;
`ifdef DMEM_ARB_ADDR_CHECK_EN
  logic        err;
`endif

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(128)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0          (req_a[0]),
    .req1          (req_a[1]),
    .we0           (we_a[0]),
    .we1           (we_a[1]),
    .addr0         (addr_a[0]),
    .addr1         (addr_a[1]),
    .wdata0        (wdata_a[0]),
    .wdata1        (wdata_a[1]),
    .gnt0          (gnt0),
    .gnt1          (gnt1),
    .rvalid0       (rvalid0),
    .rvalid1       (rvalid1),
    .rdata         (rdata),
`ifdef DMEM_ARB_ADDR_CHECK_EN
    .err           (err),
`endif
    .mem_A         (mem_A),
    .mem_WE        (mem_WE),
    .mem_WriteData (mem_WriteData),
    .mem_ReadData  (mem_ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data_memory: registered read of the old word, then write
  logic [31:0] dm [128];
  always @(posedge clk) begin
    if (mem_WE) dm[mem_A[6:0]] <= mem_WriteData;
    mem_ReadData <= dm[mem_A[6:0]];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an access is accepted at an edge unless one was
  // accepted at the previous edge; response data is the word before the write.
  logic [31:0] ref_mem [128];
  logic        m_iss_v, m_iss_port, m_iss_we, m_iss_oob;
  logic [31:0] m_iss_addr, m_iss_wdata;
  logic        m_rsp_v, m_rsp_port, m_rsp_err;
  logic [31:0] m_rsp_data;
  logic        m_last;
  logic [31:0] m_a, m_wd;

  task automatic model_step();
    logic elig;
    logic p;
    if (!rst_n) begin
      m_iss_v = 1'b0;
      m_rsp_v = 1'b0;
      m_last  = 1'b1;
      m_a     = '0;
      m_wd    = '0;
    end else begin
      elig       = !m_iss_v;
      m_rsp_v    = m_iss_v;
      m_rsp_port = m_iss_port;
      m_rsp_err  = m_iss_oob;
      m_rsp_data = m_iss_oob ? 32'd0 : ref_mem[m_iss_addr[6:0]];
      if (m_iss_v && m_iss_we && !m_iss_oob) ref_mem[m_iss_addr[6:0]] = m_iss_wdata;
      m_iss_v = 1'b0;
      if (elig && (req_a[0] || req_a[1])) begin
        p           = (req_a[0] && req_a[1]) ? !m_last : req_a[1];
        m_last      = p;
        m_iss_v     = 1'b1;
        m_iss_port  = p;
        m_iss_we    = we_a[p];
        m_iss_addr  = addr_a[p];
        m_iss_wdata = wdata_a[p];
        m_iss_oob   = OOB_CHECK && (addr_a[p] >= 32'd128);
        m_a         = addr_a[p];
        m_wd        = wdata_a[p];
      end
    end
  endtask

  task automatic check_outputs();
    chk("gnt0", gnt0, m_iss_v && !m_iss_port);
    chk("gnt1", gnt1, m_iss_v && m_iss_port);
    chk("rvalid0", rvalid0, m_rsp_v && !m_rsp_port);
    chk("rvalid1", rvalid1, m_rsp_v && m_rsp_port);
    if (m_rsp_v) chk("rdata", rdata, m_rsp_data);
    chk("mem_WE", mem_WE, m_iss_v && m_iss_we && !m_iss_oob);
    chk("mem_A", mem_A, m_a);
    chk("mem_WriteData", mem_WriteData, m_wd);
`ifdef DMEM_ARB_ADDR_CHECK_EN
    chk("err", err, m_rsp_v && m_rsp_err);
`endif
  endtask

  // Requester drivers: hold a transaction until its gnt, then load the next
  txn_t txq0[$];
  txn_t txq1[$];
  logic act [2];
  bit   rnd_mode = 1'b0;
  bit   g0_seen  = 1'b0;

  task automatic drive();
    txn_t t;
    logic g;
    bit   have;
    for (int p = 0; p < 2; p++) begin
      g = (p == 0) ? gnt0 : gnt1;
      if (p == 0 && g) g0_seen = 1'b1;
      if (g && act[p]) act[p] = 1'b0;
      if (!act[p]) begin
        have = 1'b0;
        if (p == 0 && txq0.size() > 0) begin t = txq0.pop_front(); have = 1'b1; end
        else if (p == 1 && txq1.size() > 0) begin t = txq1.pop_front(); have = 1'b1; end
        else if (rnd_mode && $urandom_range(1, 0) == 1) begin
          t.we    = 1'($urandom_range(1, 0));
          t.addr  = 32'($urandom_range(127, 0));
          t.wdata = $urandom;
          have    = 1'b1;
        end
        if (have) begin
          act[p]     = 1'b1;
          we_a[p]    = t.we;
          addr_a[p]  = t.addr;
          wdata_a[p] = t.wdata;
        end
      end
      req_a[p] = act[p];
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    drive();
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while ((txq0.size() > 0 || txq1.size() > 0 || act[0] || act[1]) && k < bound) begin
      run_cycle();
      k++;
    end
    if (k >= bound) chk("drain_timeout", 1, 0);
    repeat (4) run_cycle();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    act[0] = 1'b0; act[1] = 1'b0;
    req_a = 2'b00;
    run_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      dm[i]      = 32'hAAAA_AAAA;
      ref_mem[i] = 32'hAAAA_AAAA;
    end
    rst_n = 1'b0;
    req_a = 2'b00;
    we_a  = 2'b00;
    for (int p = 0; p < 2; p++) begin
      addr_a[p] = '0; wdata_a[p] = '0; act[p] = 1'b0;
    end
    m_iss_v = 1'b0; m_iss_port = 1'b0; m_iss_we = 1'b0; m_iss_oob = 1'b0;
    m_iss_addr = '0; m_iss_wdata = '0;
    m_rsp_v = 1'b0; m_rsp_port = 1'b0; m_rsp_err = 1'b0; m_rsp_data = '0;
    m_last = 1'b1; m_a = '0; m_wd = '0;

    // Reset state
    repeat (3) run_cycle();
    rst_n = 1'b1;

    // Single read
    txq0.push_back(txn_t'{1'b0, 32'd5, 32'd0});
    repeat (6) run_cycle();

    // Write then read back
    txq1.push_back(txn_t'{1'b1, 32'd10, 32'h1234_5678});
    repeat (5) run_cycle();
    txq0.push_back(txn_t'{1'b0, 32'd10, 32'd0});
    repeat (5) run_cycle();

    // Contention from reset
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      txq0.push_back(txn_t'{1'(i % 2), 32'(20 + i), 32'(32'hC000_0000 + i)});
      txq1.push_back(txn_t'{1'((i + 1) % 2), 32'(40 + i), 32'(32'hD000_0000 + i)});
    end
    drain(80);

    // Reset during ISSUE of a write
    g0_seen = 1'b0;
    txq0.push_back(txn_t'{1'b1, 32'd3, 32'hDEAD_BEEF});
    for (int i = 0; i < 10 && !g0_seen; i++) run_cycle();
    if (!g0_seen) chk("wait_gnt0", 0, 1);
    rst_n = 1'b0;
    #1;
    chk("mem_WE_async_rst", mem_WE, 0);
    chk("gnt0_async_rst", gnt0, 0);
    act[0] = 1'b0; act[1] = 1'b0;
    req_a  = 2'b00;
    run_cycle();
    rst_n = 1'b1;
    txq0.push_back(txn_t'{1'b0, 32'd3, 32'd0});
    drain(20);

    // Random traffic
    rnd_mode = 1'b1;
    repeat (300) run_cycle();
    rnd_mode = 1'b0;
    drain(20);

`ifdef DMEM_ARB_ADDR_CHECK_EN
    // Out-of-range read and write
    txq0.push_back(txn_t'{1'b0, 32'd200, 32'd0});
    txq1.push_back(txn_t'{1'b1, 32'd128, 32'h5555_5555});
    drain(20);
    txq1.push_back(txn_t'{1'b0, 32'd0, 32'd0});
    drain(20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
